// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch front end.
//   INST_W / ADDR_W   : instruction and address widths
//   DEFAULT_RESET_PC  : default first fetch address after reset
//   PC_INCR           : byte distance between sequential instructions
//   fetch_entry_t     : one prefetch FIFO entry {word, pc}
//   align_pc()        : forces a byte address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int ADDR_W  = 32;
    localparam int ENTRY_W = INST_W + ADDR_W;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INCR          = 32'd4;

    typedef struct packed {
        logic [INST_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Show-ahead synchronous FIFO holding prefetched {word, pc} entries.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   i_push/i_push_data : write one entry at the tail
//   i_pop           : consume the head (ignored when empty)
//   i_flush         : drop every entry; wins over a same-cycle push
//   o_pop_accepted  : the pop this cycle took an entry (also true under flush)
//   o_count         : occupancy, 0..DEPTH
//   o_head          : entry at the head (meaningful only when o_count != 0)
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_push_data,
    input  logic               i_pop,
    input  logic               i_flush,
    output logic               o_pop_accepted,
    output logic [CW-1:0]      o_count,
    output logic [ENTRY_W-1:0] o_head
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_acc;
    logic w_push_acc;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop_acc = i_pop & ~w_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_push_acc = i_push & ~i_flush & (~w_full | w_pop_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_pop_accepted = w_pop_acc;
    assign o_count        = r_count;
    assign o_head         = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction-fetch front end for the single-cycle MIPS core. Owns the fetch
// PC, drives a synchronous instruction memory (address in cycle N, data in
// N+1), buffers returned words in a prefetch FIFO and hands them to the core
// with a valid/ready handshake. A redirect flushes buffered and in-flight work.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   imem_req, imem_addr      : fetch strobe and word-aligned fetch address
//   imem_rdata               : word for the address issued last cycle
//   redirect_valid/_pc       : taken branch/jump target from the core
//   inst_valid, inst_ready   : handshake for the FIFO head
//   inst, inst_pc, inst_pc4  : head word, its address, address + 4 (0 when idle)
//   perf_stall_cnt/_flush_cnt: only with FETCH_PERF_CNT_EN defined; saturating
//                              counts of idle-output cycles and redirect cycles
// Optional feature macro: FETCH_PERF_CNT_EN
// -----------------------------------------------------------------------------
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [15:0] perf_flush_cnt
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic              r_pending;
    logic [ADDR_W-1:0] r_pending_pc;

    logic [CW-1:0]      w_count;
    logic [CW-1:0]      w_credit_used;
    logic               w_issue;
    logic               w_capture;
    logic               w_inst_valid;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head_raw;
    fetch_entry_t       w_push_entry;
    fetch_entry_t       w_head_entry;
    logic               w_pop_acc_unused;

    // Credit counts the in-flight fetch so a full FIFO never drops a response.
    // A pop in the same cycle does not free credit; it shows up next cycle.
    assign w_credit_used = w_count + CW'(r_pending);
    assign w_issue       = ~rst & ~redirect_valid & (w_credit_used < CW'(FIFO_DEPTH));

    // The response arriving during a redirect belongs to the old stream.
    assign w_capture = r_pending & ~redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc   <= RESET_PC;
            r_pending    <= 1'b0;
            r_pending_pc <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= align_pc(redirect_pc);
            r_pending  <= 1'b0;
        end else if (w_issue) begin
            r_fetch_pc   <= r_fetch_pc + PC_INCR;
            r_pending    <= 1'b1;
            r_pending_pc <= r_fetch_pc;
        end else begin
            r_pending <= 1'b0;
        end
    end

    assign w_push_entry.word = imem_rdata;
    assign w_push_entry.pc   = r_pending_pc;
    assign w_push_data       = w_push_entry;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .i_push         (w_capture),
        .i_push_data    (w_push_data),
        .i_pop          (inst_ready),
        .i_flush        (redirect_valid),
        .o_pop_accepted (w_pop_acc_unused),
        .o_count        (w_count),
        .o_head         (w_head_raw)
    );

    assign w_head_entry = fetch_entry_t'(w_head_raw);
    assign w_inst_valid = (w_count != '0);

    assign imem_req   = w_issue;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = w_inst_valid;
    // Head fields are masked so stale storage never leaks onto the core bus.
    assign inst       = w_inst_valid ? w_head_entry.word : '0;
    assign inst_pc    = w_inst_valid ? w_head_entry.pc : '0;
    assign inst_pc4   = w_inst_valid ? (w_head_entry.pc + PC_INCR) : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (~w_inst_valid && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (redirect_valid && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Directed bench for inst_fetch_unit. Instruction memory returns
// addr ^ 32'hA5A5_0000 one cycle after the address. Each step advances to
// 1 time unit past a rising edge, drives inputs, waits 1 more unit, then checks.
// Cycle 0 is the cycle in which reset is released.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [15:0] perf_flush_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    localparam logic [31:0] XOR_KEY = 32'hA5A5_0000;

    always #5 clk = ~clk;

    always @(posedge clk) imem_rdata <= imem_addr ^ XOR_KEY;

    inst_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Checks a valid head: pc, paired data and pc+4.
    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, pc ^ XOR_KEY);
        chk({tag, "_pc4"}, inst_pc4, pc + 32'd4);
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_pc4", inst_pc4, 32'h0);

        // ---- stream: cycle 0 issues PC 0 ----
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk("c1_valid", 32'(inst_valid), 32'd0);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_req", 32'(imem_req), 32'd1);
        next(); #1;
        // cycles 2..9 present PCs 0,4,...,28 back to back
        for (int k = 0; k < 8; k++) begin
            chk_head("stream", 32'(4 * k));
            next(); #1;
        end

        // ---- backpressure: ready low for cycles 10..19, head stays PC 32 ----
        inst_ready = 1'b0;
        #1;
        chk("bp10_req", 32'(imem_req), 32'd1);
        chk_head("bp10", 32'd32);
        next(); #1;
        chk("bp11_req", 32'(imem_req), 32'd1);
        next(); #1;
        chk("bp12_req", 32'(imem_req), 32'd0);
        for (int c = 13; c < 20; c++) begin
            next(); #1;
            chk("bp_full_req", 32'(imem_req), 32'd0);
            chk("bp_full_addr", imem_addr, 32'd48);
            chk_head("bp_full", 32'd32);
        end
        // cycle 20: ready back; pop does not give credit this cycle
        next();
        inst_ready = 1'b1;
        #1;
        chk("bp20_req", 32'(imem_req), 32'd0);
        chk_head("bp20", 32'd32);
        next(); #1;
        chk("bp21_req", 32'(imem_req), 32'd1);
        chk("bp21_addr", imem_addr, 32'd48);
        chk_head("bp21", 32'd36);
        next(); #1;
        chk("bp22_req", 32'(imem_req), 32'd1);
        chk_head("bp22", 32'd40);
        for (int k = 0; k < 5; k++) begin
            next(); #1;
            chk_head("resume", 32'(44 + 4 * k));
        end

        // ---- redirect mid-stream at R, head 64 consumed in R ----
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("rd_R_req", 32'(imem_req), 32'd0);
        chk_head("rd_R", 32'd64);
        next();
        redirect_valid = 1'b0;
        #1;
        chk("rd_R1_valid", 32'(inst_valid), 32'd0);
        chk("rd_R1_req", 32'(imem_req), 32'd1);
        chk("rd_R1_addr", imem_addr, 32'h100);
        next(); #1;
        chk("rd_R2_valid", 32'(inst_valid), 32'd0);
        chk("rd_R2_addr", imem_addr, 32'h104);
        next(); #1;
        chk_head("rd_R3", 32'h100);
        next(); #1;
        chk_head("rd_R4", 32'h104);

        // ---- fill FIFO, then redirect coincident with pop of a full FIFO ----
        next();
        inst_ready = 1'b0;
        #1;
        chk("fl5_req", 32'(imem_req), 32'd1);
        chk_head("fl5", 32'h108);
        next(); #1;
        chk("fl6_req", 32'(imem_req), 32'd1);
        next(); #1;
        chk("fl7_req", 32'(imem_req), 32'd0);
        next();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk("fl8_req", 32'(imem_req), 32'd0);
        chk_head("fl8", 32'h108);
        next();
        redirect_valid = 1'b0;
        #1;
        chk("fl9_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk("fl10_valid", 32'(inst_valid), 32'd0);
        chk("fl10_addr", imem_addr, 32'h204);
        next(); #1;
        chk_head("fl11", 32'h200);
        next(); #1;
        chk_head("fl12", 32'h204);

        // ---- back-to-back redirects: last one wins ----
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        #1;
        chk("bb0_req", 32'(imem_req), 32'd0);
        chk_head("bb0", 32'h208);
        next();
        redirect_pc = 32'h0000_0400;
        #1;
        chk("bb1_req", 32'(imem_req), 32'd0);
        chk("bb1_valid", 32'(inst_valid), 32'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        chk("bb2_req", 32'(imem_req), 32'd1);
        chk("bb2_addr", imem_addr, 32'h400);
        chk("bb2_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk("bb3_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk_head("bb4", 32'h400);

        // ---- wrap at top of address space ----
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        #1;
        chk("wr0_req", 32'(imem_req), 32'd0);
        next();
        redirect_valid = 1'b0;
        #1;
        chk("wr1_valid", 32'(inst_valid), 32'd0);
        chk("wr1_addr", imem_addr, 32'hFFFF_FFFC);
        next(); #1;
        chk("wr2_addr", imem_addr, 32'h0);
        next(); #1;
        chk("wr3_valid", 32'(inst_valid), 32'd1);
        chk("wr3_pc", inst_pc, 32'hFFFF_FFFC);
        chk("wr3_inst", inst, 32'h5A5A_FFFC);
        chk("wr3_pc4", inst_pc4, 32'h0);
        next(); #1;
        chk("wr4_pc", inst_pc, 32'h0);
        chk("wr4_inst", inst, 32'hA5A5_0000);
        chk("wr4_pc4", inst_pc4, 32'h4);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_flush", 32'(perf_flush_cnt), 32'd5);
`endif

        // ---- asynchronous reset between edges ----
        #1;
        rst = 1'b1;
        #1;
        chk("ar_valid", 32'(inst_valid), 32'd0);
        chk("ar_req", 32'(imem_req), 32'd0);
        chk("ar_addr", imem_addr, 32'h0);
        chk("ar_inst", inst, 32'h0);
        chk("ar_pc", inst_pc, 32'h0);
        chk("ar_pc4", inst_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("ar_perf_stall", perf_stall_cnt, 32'd0);
        chk("ar_perf_flush", 32'(perf_flush_cnt), 32'd0);
`endif
        next();
        next();
        rst = 1'b0;
        #1;
        chk("rr0_req", 32'(imem_req), 32'd1);
        chk("rr0_addr", imem_addr, 32'h0);
        chk("rr0_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk("rr1_valid", 32'(inst_valid), 32'd0);
        next(); #1;
        chk_head("rr2", 32'h0);
        next(); #1;
        chk_head("rr3", 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end that feeds the single-cycle MIPS decode/execute datapath.
- Owns the fetch PC and drives the synchronous instruction memory (address in cycle N, data returned in cycle N+1).
- Buffers returned words in a small prefetch FIFO and presents them to the core with a valid/ready handshake.
- Accepts branch/jump redirects from the core; a redirect flushes all buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, prefetch entries; power of two, at least 2.

Ports:
- clk  in  1  single clock, all state on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch issue strobe for this cycle.
- imem_addr  out  32  word-aligned fetch address.
- imem_rdata  in  32  instruction word for the address issued in the previous cycle.
- redirect_valid  in  1  core requests a PC change (taken branch/jump).
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- inst_valid  out  1  FIFO head holds a valid instruction.
- inst_ready  in  1  core consumes the head this cycle.
- inst  out  32  instruction word at the FIFO head.
- inst_pc  out  32  address of inst.
- inst_pc4  out  32  inst_pc + 4, for link and branch-base use.

Behaviour:
- State:
  - fetch_pc (32 bits).
  - FIFO of {word, pc}, with count in 0..FIFO_DEPTH.
  - pending bit and pending_pc, tracking one in-flight fetch.
- Reset (asynchronous, rst=1):
  - fetch_pc=RESET_PC, count=0, pending=0.
  - imem_req=0, inst_valid=0, inst/inst_pc/inst_pc4=0.
  - imem_addr=RESET_PC.
- Issue condition:
  - imem_req = !rst & !redirect_valid & (count + pending < FIFO_DEPTH).
  - A pop in the same cycle does not add credit.
  - imem_addr = fetch_pc at all times.
- On issue:
  - fetch_pc <= fetch_pc+4, wrapping modulo 2^32.
  - pending <= 1, pending_pc <= fetch_pc.
  - Otherwise pending <= 0.
- Capture: when pending=1 and redirect_valid=0, {imem_rdata, pending_pc} is pushed at the end of that cycle.
- Latency:
  - Issue in cycle N, push at end of N+1, inst_valid in N+2.
  - First inst_valid is on the 3rd rising edge after reset release (issue cycle 0).
- Output masking: inst_valid = (count != 0). inst/inst_pc/inst_pc4 read 0 when inst_valid=0.
- Pop: inst_valid & inst_ready removes the head. Simultaneous push and pop leaves count unchanged.
- Redirect (cycle R, redirect_valid=1):
  - A handshake that completes in cycle R is honoured; the core keeps that instruction.
  - At the end of R: count <= 0, pending <= 0, the response arriving in R is discarded, and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - No issue occurs in R. First issue is in R+1; first new inst_valid is in R+3.
- Full FIFO: no issue, and no word is lost, because credit reserves a slot for the in-flight fetch.
- Empty FIFO: inst_valid=0; inst_ready is ignored.
- Back-to-back redirects: each flushes; the last one wins.
- Throughput: 1 instruction/cycle in steady state with inst_ready held at 1.
- Reset asserted mid-operation: all state cleared immediately (asynchronous), and in-flight data is dropped.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - perf_stall_cnt [31:0]: counts cycles with inst_valid=0 while rst=0.
  - perf_flush_cnt [15:0]: counts cycles with redirect_valid=1.
  - Both saturate at all-ones and reset to 0.
- When undefined: the ports and counters are absent, and all other behaviour is identical.

Decomposition:
- Package fetch_pkg:
  - INST_W=32 and ADDR_W=32.
  - Default RESET_PC.
  - Pc-increment constant 4.
  - Packed struct fetch_entry_t {word, pc}.
- Sub-module fetch_fifo: synchronous FIFO with push, pop, flush, count and head outputs.
  - Flush has priority over push.
  - A pop in the same cycle as a flush is still reported as accepted.

Test Plan:
- Stream: release reset; imem returns rdata = addr ^ 32'hA5A5_0000; inst_ready=1.
  - Expect inst_valid on the 3rd edge, then inst_pc = 0,4,8,... with one instruction per cycle.
  - Expect inst_pc4 = inst_pc+4 and correct data pairing.
- Backpressure: inst_ready=0 for 10 cycles.
  - count saturates at 4 and imem_req drops when count+pending reaches 4.
  - After ready returns: no lost or duplicate PCs, and the sequence resumes contiguously.
- Redirect mid-stream: redirect_valid for 1 cycle at R with redirect_pc=32'h0000_0103.
  - No imem_req in R.
  - Next inst_pc = 32'h0000_0100 at R+3.
  - No stale pre-redirect entry is ever visible after R.
- Redirect coincident with pop and with a full FIFO: the popped word is delivered once and all other entries are flushed.
- Wrap: redirect_pc=32'hFFFF_FFFC; expect inst_pc FFFF_FFFC then 0000_0000.
- Async reset mid-stream: assert rst between edges.
  - Immediately inst_valid=0, imem_req=0, imem_addr=RESET_PC.
  - Refetch from RESET_PC after release.
  - With FETCH_PERF_CNT_EN: counters read 0.
